ewb_tagged: RTL and testbench

- Parametrised eviction write buffer for the L2 cache. It sits between the L2 eviction path and the memory-side arbiter.
- Each entry holds a line address and its dirty line data.
- The buffer drains to memory in FIFO order using a valid-yumi handshake.
- A combinational lookup port lets L2 miss handling forward a pending victim line instead of reading stale memory. Optional same-address coalescing is described below.

---
 rtl/ewb_tagged_if.sv | 35 +++
 rtl/ewb_tagged.sv | 119 +++++++++++
 tb/tb_ewb_tagged.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/ewb_tagged_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ewb_tagged_if                                                   |
// | Brief    : Enqueue, drain and lookup bundle for the ewb_tagged buffer.     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface ewb_tagged_if #(
    parameter int DATA_W     = 256,
    parameter int ADDR_W     = 27,
    parameter int DEPTH_LOG2 = 2
);
    logic [ADDR_W-1:0]     addr_i;
    logic [DATA_W-1:0]     data_i;
    logic                  valid_i;
    logic                  ready_o;
    logic                  valid_o;
    logic [ADDR_W-1:0]     addr_o;
    logic [DATA_W-1:0]     data_o;
    logic                  yumi_i;
    logic [ADDR_W-1:0]     lkp_addr_i;
    logic                  lkp_hit_o;
    logic [DATA_W-1:0]     lkp_data_o;
    logic [DEPTH_LOG2:0]   count_o;

    modport master (
        output addr_i, data_i, valid_i, yumi_i, lkp_addr_i,
        input  ready_o, valid_o, addr_o, data_o, lkp_hit_o, lkp_data_o, count_o
    );

    modport slave (
        input  addr_i, data_i, valid_i, yumi_i, lkp_addr_i,
        output ready_o, valid_o, addr_o, data_o, lkp_hit_o, lkp_data_o, count_o
    );
endinterface
`default_nettype wire

// File: rtl/ewb_tagged.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ewb_tagged                                                      |
// | Brief    : L2 eviction write buffer, FIFO drain with youngest-match lookup.|
// |            Define EWB_COALESCE_EN to merge same-address non-head enqueues. |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module ewb_tagged #(
    parameter int DATA_W     = 256,
    parameter int ADDR_W     = 27,
    parameter int DEPTH_LOG2 = 2
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    ewb_tagged_if.slave      bus
);
    localparam int                  c_DEPTH   = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] c_PTR_ONE = (DEPTH_LOG2+1)'(1);

    logic [DEPTH_LOG2:0]   r_wr_ptr;
    logic [DEPTH_LOG2:0]   r_rd_ptr;
    logic [ADDR_W-1:0]     r_addr [c_DEPTH];
    logic [DATA_W-1:0]     r_data [c_DEPTH];

    logic [DEPTH_LOG2:0]   w_count;
    logic [DEPTH_LOG2-1:0] w_rd_idx;
    logic [DEPTH_LOG2-1:0] w_wr_idx;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_enq;
    logic                  w_deq;
    logic                  w_alloc;
    logic [DEPTH_LOG2-1:0] w_slot [c_DEPTH];
    logic [c_DEPTH-1:0]    w_occ;
    logic                  w_lkp_hit;
    logic [DATA_W-1:0]     w_lkp_data;

    assign w_rd_idx = r_rd_ptr[DEPTH_LOG2-1:0];
    assign w_wr_idx = r_wr_ptr[DEPTH_LOG2-1:0];
    assign w_count  = r_wr_ptr - r_rd_ptr;
    assign w_empty  = (r_wr_ptr == r_rd_ptr);
    assign w_full   = (w_wr_idx == w_rd_idx) && (r_wr_ptr[DEPTH_LOG2] != r_rd_ptr[DEPTH_LOG2]);
    assign w_enq    = bus.valid_i & ~w_full;
    assign w_deq    = bus.yumi_i & ~w_empty;

    // Slot i holds the entry of age i (0 = head); occupied when age < count.
    for (genvar i = 0; i < c_DEPTH; i++) begin : g_slot
        assign w_slot[i] = w_rd_idx + DEPTH_LOG2'(i);
        assign w_occ[i]  = ((DEPTH_LOG2+1)'(i) < w_count);
    end

    // Scan oldest to youngest so the youngest match is the one left standing.
    always_comb begin
        w_lkp_hit  = 1'b0;
        w_lkp_data = r_data[w_rd_idx];
        for (int i = 0; i < c_DEPTH; i++) begin
            if (w_occ[i] && (r_addr[w_slot[i]] == bus.lkp_addr_i)) begin
                w_lkp_hit  = 1'b1;
                w_lkp_data = r_data[w_slot[i]];
            end
        end
    end

`ifdef EWB_COALESCE_EN
    logic                  w_coal;
    logic [DEPTH_LOG2-1:0] w_coal_idx;

    // Age 0 is skipped: the head may already be mid-transfer downstream.
    always_comb begin
        w_coal     = 1'b0;
        w_coal_idx = w_slot[0];
        for (int i = 1; i < c_DEPTH; i++) begin
            if (w_occ[i] && (r_addr[w_slot[i]] == bus.addr_i)) begin
                w_coal     = 1'b1;
                w_coal_idx = w_slot[i];
            end
        end
    end

    assign w_alloc = w_enq & ~w_coal;
`else
    assign w_alloc = w_enq;
`endif

    always_ff @(posedge clk) begin
        if (w_alloc) begin
            r_addr[w_wr_idx] <= bus.addr_i;
            r_data[w_wr_idx] <= bus.data_i;
        end
`ifdef EWB_COALESCE_EN
        if (w_enq && w_coal) begin
            r_data[w_coal_idx] <= bus.data_i;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_alloc) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_deq) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
        end
    end

    assign bus.ready_o    = ~w_full;
    assign bus.valid_o    = ~w_empty;
    assign bus.addr_o     = r_addr[w_rd_idx];
    assign bus.data_o     = r_data[w_rd_idx];
    assign bus.count_o    = w_count;
    assign bus.lkp_hit_o  = w_lkp_hit;
    assign bus.lkp_data_o = w_lkp_data;
endmodule
`default_nettype wire

// File: tb/tb_ewb_tagged.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module   : tb_ewb_tagged                                                   |
// | Brief    : Queue-model bench for ewb_tagged, directed plus random traffic. |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_ewb_tagged;
    localparam int DATA_W     = 256;
    localparam int ADDR_W     = 27;
    localparam int DEPTH_LOG2 = 2;
    localparam int DEPTH      = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    bit   chk_en = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    logic [ADDR_W-1:0] m_addr [$];
    logic [DATA_W-1:0] m_data [$];

    always #5 clk = ~clk;

    ewb_tagged_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH_LOG2(DEPTH_LOG2)) bus ();

    ewb_tagged #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH_LOG2(DEPTH_LOG2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic [DATA_W-1:0] pat(input logic [31:0] s);
        return {8{s}};
    endfunction

    task automatic chk(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // Reference: a plain queue, oldest first.
    always @(posedge clk or negedge rst_n) begin : model
        bit enq, deq, coal;
        if (!rst_n) begin
            m_addr.delete();
            m_data.delete();
        end else begin
            enq  = bus.valid_i && (m_addr.size() < DEPTH);
            deq  = bus.yumi_i && (m_addr.size() > 0);
            coal = 1'b0;
`ifdef EWB_COALESCE_EN
            if (enq) begin
                for (int j = m_addr.size() - 1; j >= 1; j--) begin
                    if (!coal && m_addr[j] == bus.addr_i) begin
                        coal      = 1'b1;
                        m_data[j] = bus.data_i;
                    end
                end
            end
`endif
            if (deq) begin
                void'(m_addr.pop_front());
                void'(m_data.pop_front());
            end
            if (enq && !coal) begin
                m_addr.push_back(bus.addr_i);
                m_data.push_back(bus.data_i);
            end
        end
    end

    task automatic compare();
        bit                hit;
        logic [DATA_W-1:0] ld;
        int                n;
        n   = m_addr.size();
        hit = 1'b0;
        ld  = '0;
        for (int j = 0; j < n; j++) begin
            if (m_addr[j] == bus.lkp_addr_i) begin
                hit = 1'b1;
                ld  = m_data[j];
            end
        end
        chk("valid_o", DATA_W'(bus.valid_o), DATA_W'(n > 0));
        chk("ready_o", DATA_W'(bus.ready_o), DATA_W'(n < DEPTH));
        chk("count_o", DATA_W'(bus.count_o), DATA_W'(n));
        chk("lkp_hit_o", DATA_W'(bus.lkp_hit_o), DATA_W'(hit));
        if (n > 0) begin
            chk("addr_o", DATA_W'(bus.addr_o), DATA_W'(m_addr[0]));
            chk("data_o", bus.data_o, m_data[0]);
        end
        if (hit) chk("lkp_data_o", bus.lkp_data_o, ld);
    endtask

    always @(negedge clk) begin
        #2;
        if (chk_en) compare();
    end

    // Drive one cycle of inputs; returns mid-cycle so callers can inspect outputs.
    task automatic step(input bit v, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                        input bit y, input logic [ADDR_W-1:0] la);
        @(negedge clk);
        #1;
        bus.valid_i    = v;
        bus.addr_i     = a;
        bus.data_i     = d;
        bus.yumi_i     = y;
        bus.lkp_addr_i = la;
        #2;
    endtask

    task automatic idle(input logic [ADDR_W-1:0] la);
        step(1'b0, '0, '0, 1'b0, la);
    endtask

    task automatic drain();
        for (int k = 0; k < 2 * DEPTH; k++) step(1'b0, '0, '0, 1'b1, '0);
        idle('0);
    endtask

    initial begin
        logic [DATA_W-1:0] rd;
        bus.valid_i = 1'b0; bus.addr_i = '0; bus.data_i = '0;
        bus.yumi_i = 1'b0; bus.lkp_addr_i = '0;
        @(posedge clk);
        #1 chk_en = 1'b1;
        idle('0);
        rst_n = 1'b1;
        idle('0);
        chk("rst_valid", DATA_W'(bus.valid_o), '0);
        chk("rst_ready", DATA_W'(bus.ready_o), DATA_W'(1));
        chk("rst_count", DATA_W'(bus.count_o), '0);

        // Fill then drain
        for (int n = 0; n < 4; n++) step(1'b1, ADDR_W'(32'h10 + n), pat(32'hD000_0000 + n), 1'b0, '0);
        idle('0);
        chk("fill_count", DATA_W'(bus.count_o), DATA_W'(4));
        chk("fill_ready", DATA_W'(bus.ready_o), '0);
        chk("fill_head", DATA_W'(bus.addr_o), DATA_W'(32'h10));
        for (int n = 0; n < 4; n++) begin
            step(1'b0, '0, '0, 1'b1, '0);
            chk("drain_addr", DATA_W'(bus.addr_o), DATA_W'(32'h10 + n));
            chk("drain_data", bus.data_o, pat(32'hD000_0000 + n));
        end
        idle('0);
        chk("drain_valid", DATA_W'(bus.valid_o), '0);
        chk("drain_count", DATA_W'(bus.count_o), '0);

        // Wrap with simultaneous enqueue/dequeue at occupancy 1
        step(1'b1, ADDR_W'(32'h1F), pat(32'h1F), 1'b0, '0);
        for (int n = 0; n < 10; n++) begin
            step(1'b1, ADDR_W'(32'h20 + n), pat(32'h20 + n), 1'b1, '0);
            chk("wrap_count", DATA_W'(bus.count_o), DATA_W'(1));
            chk("wrap_addr", DATA_W'(bus.addr_o), DATA_W'((n == 0) ? 32'h1F : 32'h1F + n));
        end
        drain();

        // Lookup picks the youngest duplicate
        step(1'b1, ADDR_W'(32'h40), pat(32'hDA), 1'b0, '0);
        step(1'b1, ADDR_W'(32'h41), pat(32'hDB), 1'b0, '0);
        step(1'b1, ADDR_W'(32'h40), pat(32'hDC), 1'b0, '0);
        idle(ADDR_W'(32'h40));
        chk("lkp_hit", DATA_W'(bus.lkp_hit_o), DATA_W'(1));
        chk("lkp_data", bus.lkp_data_o, pat(32'hDC));
        idle(ADDR_W'(32'h55));
        chk("lkp_miss", DATA_W'(bus.lkp_hit_o), '0);
        drain();

`ifdef EWB_COALESCE_EN
        step(1'b1, ADDR_W'(32'h40), pat(32'hDA), 1'b0, '0);
        step(1'b1, ADDR_W'(32'h41), pat(32'hDB), 1'b0, '0);
        step(1'b1, ADDR_W'(32'h41), pat(32'hDE), 1'b0, '0);
        idle(ADDR_W'(32'h41));
        chk("coal_count", DATA_W'(bus.count_o), DATA_W'(2));
        chk("coal_data", bus.lkp_data_o, pat(32'hDE));
        step(1'b1, ADDR_W'(32'h40), pat(32'hDF), 1'b0, '0);
        idle('0);
        chk("coal_head_alloc", DATA_W'(bus.count_o), DATA_W'(3));
        drain();
`endif

        // Full stall with concurrent dequeue
        for (int n = 0; n < 4; n++) step(1'b1, ADDR_W'(32'h60 + n), pat(32'h60 + n), 1'b0, '0);
        step(1'b1, ADDR_W'(32'h70), pat(32'h70), 1'b1, '0);
        chk("stall_ready", DATA_W'(bus.ready_o), '0);
        idle(ADDR_W'(32'h70));
        chk("stall_count", DATA_W'(bus.count_o), DATA_W'(3));
        chk("stall_ready_after", DATA_W'(bus.ready_o), DATA_W'(1));
        chk("stall_no_enq", DATA_W'(bus.lkp_hit_o), '0);
        drain();

        // Asynchronous reset between edges
        for (int n = 0; n < 3; n++) step(1'b1, ADDR_W'(32'h80 + n), pat(32'h80 + n), 1'b0, '0);
        idle(ADDR_W'(32'h80));
        chk("pre_rst_count", DATA_W'(bus.count_o), DATA_W'(3));
        #1 rst_n = 1'b0;
        #1;
        chk("arst_valid", DATA_W'(bus.valid_o), '0);
        chk("arst_count", DATA_W'(bus.count_o), '0);
        chk("arst_ready", DATA_W'(bus.ready_o), DATA_W'(1));
        chk("arst_hit", DATA_W'(bus.lkp_hit_o), '0);
        @(negedge clk);
        #4 rst_n = 1'b1;
        step(1'b1, ADDR_W'(32'h90), pat(32'h90), 1'b0, '0);
        idle('0);
        chk("post_rst_valid", DATA_W'(bus.valid_o), DATA_W'(1));
        chk("post_rst_addr", DATA_W'(bus.addr_o), DATA_W'(32'h90));
        drain();

        // Random traffic over a small address pool to provoke duplicates
        for (int c = 0; c < 3000; c++) begin
            for (int w = 0; w < 8; w++) rd[w*32 +: 32] = $urandom;
            step(($urandom_range(0, 99) < 60), ADDR_W'(32'h100 + $urandom_range(0, 5)), rd,
                 ($urandom_range(0, 99) < 45), ADDR_W'(32'h100 + $urandom_range(0, 6)));
            if (c == 1500) begin
                #1 rst_n = 1'b0;
                @(negedge clk);
                #4 rst_n = 1'b1;
            end
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire
